// File: rtl/sc_io_pkg.sv
// Shared constants for the sc_io_input front end: default sizes, io_in field
// offsets and the idle (released) level of the active-low push-keys.
package sc_io_pkg;

    localparam int SW_W_DEF            = 10;
    localparam int KEY_W_DEF           = 3;
    localparam int DEBOUNCE_CYCLES_DEF = 50000;

    localparam int SW_LSB  = 0;
    localparam int KEY_LSB = SW_W_DEF;

    localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/sc_debounce.sv
// One input bit: 2-flop synchronizer, stable-sample counter and debounced level.
// leave_o pulses on the edge where the stable value moves away from its reset level.
module sc_debounce #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RST_LEVEL       = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o,
    output logic leave_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q;
    logic             armed_q;
    logic [1:0]       warm_q;
    logic [CNT_W-1:0] cnt_q;
    logic             update;

    assign update   = (sync_q != stable_q) && (cnt_q == CNT_LAST);
    assign stable_o = stable_q;
    assign leave_o  = update && (stable_q == RST_LEVEL) && armed_q;

    // armed_q only sets once a real (post-reset) synchronized sample shows the
    // idle level, so an input held active through reset never reports a leave.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q   <= RST_LEVEL;
            sync_q   <= RST_LEVEL;
            stable_q <= RST_LEVEL;
            armed_q  <= 1'b0;
            warm_q   <= 2'd0;
            cnt_q    <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            if (warm_q != 2'd2) begin
                warm_q <= warm_q + 2'd1;
            end
            if ((warm_q == 2'd2) && (sync_q == RST_LEVEL)) begin
                armed_q <= 1'b1;
            end
            if (sync_q == stable_q) begin
                cnt_q <= '0;
            end else if (update) begin
                stable_q <= sync_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sc_io_input.sv
// Input front end: debounced switches plus sticky key-press events, packed into io_in.
// Optional feature macro: SC_IO_IRQ_EN adds the registered irq output.
module sc_io_input
    import sc_io_pkg::*;
#(
    parameter int SW_W            = SW_W_DEF,
    parameter int KEY_W           = KEY_W_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [SW_W-1:0]       sw_raw,
    input  logic [KEY_W-1:0]      key_raw,
    input  logic                  key_rd,
    output logic [SW_W+KEY_W-1:0] io_in
`ifdef SC_IO_IRQ_EN
    ,
    output logic                  irq
`endif
);

    logic [SW_W-1:0]  swStable;
    logic [SW_W-1:0]  unusedSwLeave;
    logic [KEY_W-1:0] unusedKeyStable;
    logic [KEY_W-1:0] keyPress;
    logic [KEY_W-1:0] keyEvent_q;
    logic [KEY_W-1:0] keyEvent_d;

    for (genvar i = 0; i < SW_W; i++) begin : gSw
        sc_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RST_LEVEL      (1'b0)
        ) uDebounce (
            .clock   (clock),
            .reset   (reset),
            .raw_i   (sw_raw[i]),
            .stable_o(swStable[i]),
            .leave_o (unusedSwLeave[i])
        );
    end

    // A key leaving its released level is a press.
    for (genvar i = 0; i < KEY_W; i++) begin : gKey
        sc_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RST_LEVEL      (KEY_RELEASED)
        ) uDebounce (
            .clock   (clock),
            .reset   (reset),
            .raw_i   (key_raw[i]),
            .stable_o(unusedKeyStable[i]),
            .leave_o (keyPress[i])
        );
    end

    always_comb begin
        keyEvent_d = (key_rd ? '0 : keyEvent_q) | keyPress;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            keyEvent_q <= '0;
        end else begin
            keyEvent_q <= keyEvent_d;
        end
    end

`ifdef SC_IO_IRQ_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |keyEvent_d;
        end
    end
`endif

    assign io_in[SW_LSB +: SW_W]          = swStable;
    assign io_in[SW_LSB + SW_W +: KEY_W]  = keyEvent_q;

endmodule

// File: tb/tb_sc_io_input.sv
// Self-checking bench for sc_io_input with DEBOUNCE_CYCLES=8: hand-computed
// vector table, corner-case sequences and a random run against a window model.
module tb_sc_io_input;
    import sc_io_pkg::*;

    localparam int DC = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  swRaw = '0;
    logic [2:0]  keyRaw = 3'b000;
    logic        keyRd = 1'b0;
    logic [12:0] ioIn;
`ifdef SC_IO_IRQ_EN
    logic        irqOut;
`endif

    int total = 0;
    int bad = 0;

    sc_io_input #(
        .SW_W           (10),
        .KEY_W          (3),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .sw_raw (swRaw),
        .key_raw(keyRaw),
        .key_rd (keyRd),
        .io_in  (ioIn)
`ifdef SC_IO_IRQ_EN
        ,
        .irq    (irqOut)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: a raw sample reaches the debouncer two edges later; a bit
    // flips once its last DC synchronized samples all differ from the stable value.
    typedef struct {
        bit          isReal;
        logic [12:0] v;
    } samp_t;

    samp_t       pipeQ[$];
    logic [12:0] winQ[$];
    logic [12:0] mStable;
    logic [2:0]  mEvent;
    logic [2:0]  mArmed;
    logic        mIrq;

    typedef struct {
        string       name;
        logic [9:0]  sw;
        logic [2:0]  key;
        logic        rd;
        int          cycles;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [12:0] act, input logic [12:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkIrq(input string name, input logic exp);
`ifdef SC_IO_IRQ_EN
        checkOutput(name, {12'b0, irqOut}, {12'b0, exp});
`else
        if (exp === 1'bx) $display("[TB] %s", name);
`endif
    endtask

    task automatic modelReset();
        samp_t s;
        s.isReal = 1'b0;
        s.v      = {3'b111, 10'b0};
        pipeQ.delete();
        winQ.delete();
        pipeQ.push_back(s);
        pipeQ.push_back(s);
        mStable = {3'b111, 10'b0};
        mEvent  = '0;
        mArmed  = '0;
        mIrq    = 1'b0;
    endtask

    task automatic modelEdge(input logic [12:0] raw, input logic rd);
        samp_t       s;
        samp_t       n;
        logic [12:0] syn;
        logic [2:0]  press;
        bit          allDiff;
        s = pipeQ.pop_front();
        n.isReal = 1'b1;
        n.v      = raw;
        pipeQ.push_back(n);
        syn = s.v;
        winQ.push_back(syn);
        if (winQ.size() > DC) void'(winQ.pop_front());
        press = '0;
        if (winQ.size() == DC) begin
            for (int b = 0; b < 13; b++) begin
                allDiff = 1'b1;
                foreach (winQ[k]) if (winQ[k][b] == mStable[b]) allDiff = 1'b0;
                if (allDiff) begin
                    if (b >= 10 && mStable[b] == 1'b1 && mArmed[b-10]) press[b-10] = 1'b1;
                    mStable[b] = ~mStable[b];
                end
            end
        end
        if (s.isReal) mArmed = mArmed | syn[12:10];
        mEvent = (rd ? 3'b000 : mEvent) | press;
        mIrq   = |mEvent;
    endtask

    task automatic applyStimulus(input logic [9:0] sw, input logic [2:0] key, input logic rd);
        swRaw  = sw;
        keyRaw = key;
        keyRd  = rd;
        @(posedge clock);
        modelEdge({key, sw}, rd);
        #1;
        keyRd = 1'b0;
        checkOutput("model_io", ioIn, {mEvent, mStable[9:0]});
`ifdef SC_IO_IRQ_EN
        checkOutput("model_irq", {12'b0, irqOut}, {12'b0, mIrq});
`endif
    endtask

    task automatic doReset();
        reset = 1'b1;
        modelReset();
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_io", ioIn, 13'h0000);
        checkIrq("reset_irq", 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        logic [9:0] rs;
        logic [2:0] rk;
        int         hold;

        $display("[TB] start");
        vecs.push_back('{"s1_hold",         10'h000, 3'b000, 1'b0, 20, 13'h0000});
        vecs.push_back('{"s1_release0",     10'h000, 3'b001, 1'b0, 12, 13'h0000});
        vecs.push_back('{"s1_press0_early", 10'h000, 3'b000, 1'b0,  9, 13'h0000});
        vecs.push_back('{"s1_press0",       10'h000, 3'b000, 1'b0,  1, 13'h0400});
        vecs.push_back('{"s1_rd",           10'h000, 3'b000, 1'b1,  1, 13'h0000});
        vecs.push_back('{"s2_early",        10'h2A5, 3'b111, 1'b0,  9, 13'h0000});
        vecs.push_back('{"s2_exact",        10'h2A5, 3'b111, 1'b0,  1, 13'h02A5});
        vecs.push_back('{"s3_base",         10'h2A4, 3'b111, 1'b0, 10, 13'h02A4});
        for (int p = 0; p < 8; p++) begin
            vecs.push_back('{"s3_toggle", (p % 2 == 0) ? 10'h2A5 : 10'h2A4, 3'b111, 1'b0, 5, 13'h02A4});
        end
        vecs.push_back('{"s3_hold_early",   10'h2A5, 3'b111, 1'b0,  9, 13'h02A4});
        vecs.push_back('{"s3_hold",         10'h2A5, 3'b111, 1'b0,  1, 13'h02A5});

        swRaw  = '0;
        keyRaw = 3'b000;
        doReset();

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].cycles; c++) begin
                applyStimulus(vecs[i].sw, vecs[i].key, (c == 0) ? vecs[i].rd : 1'b0);
            end
            checkOutput(vecs[i].name, ioIn, vecs[i].exp);
        end

        // Key 1 press, clear, and no re-set while still held
        repeat (9) applyStimulus(10'h2A5, 3'b101, 1'b0);
        checkOutput("s4_before", ioIn, 13'h02A5);
        applyStimulus(10'h2A5, 3'b101, 1'b0);
        checkOutput("s4_event", ioIn, 13'h0AA5);
        checkIrq("s6_irq_rise", 1'b1);
        applyStimulus(10'h2A5, 3'b101, 1'b1);
        checkOutput("s4_rd", ioIn, 13'h02A5);
        checkIrq("s4_irq_fall", 1'b0);
        repeat (15) applyStimulus(10'h2A5, 3'b101, 1'b0);
        checkOutput("s4_no_reset", ioIn, 13'h02A5);

        // key_rd lands on the very edge where key 2 is accepted as pressed
        repeat (12) applyStimulus(10'h2A5, 3'b111, 1'b0);
        checkOutput("s5_release", ioIn, 13'h02A5);
        repeat (10) applyStimulus(10'h2A5, 3'b110, 1'b0);
        checkOutput("s5_key0", ioIn, 13'h06A5);
        repeat (9) applyStimulus(10'h2A5, 3'b010, 1'b0);
        checkOutput("s5_pre", ioIn, 13'h06A5);
        applyStimulus(10'h2A5, 3'b010, 1'b1);
        checkOutput("s5_set_wins", {10'b0, ioIn[KEY_LSB +: 3]}, 13'h0004);
        checkIrq("s6_irq_hold", 1'b1);
        applyStimulus(10'h2A5, 3'b010, 1'b1);
        checkOutput("s6_clear", ioIn, 13'h02A5);
        checkIrq("s6_irq_fall", 1'b0);

        // Reset partway through a switch debounce restarts the full latency
        repeat (5) applyStimulus(10'h155, 3'b111, 1'b0);
        checkOutput("mid_before", ioIn, 13'h02A5);
        doReset();
        repeat (9) applyStimulus(10'h155, 3'b111, 1'b0);
        checkOutput("mid_early", ioIn, 13'h0000);
        applyStimulus(10'h155, 3'b111, 1'b0);
        checkOutput("mid_exact", ioIn, 13'h0155);

        rs = 10'h155;
        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 1) == 1) rs = rs ^ 10'($urandom_range(0, 1023));
            rk   = 3'($urandom_range(0, 7));
            hold = int'($urandom_range(1, 14));
            for (int c = 0; c < hold; c++) begin
                applyStimulus(rs, rk, ($urandom_range(0, 5) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sc_io_input.md
# sc_io_input

Input-side peripheral front end for the single-cycle computer: synchronizes and debounces the raw board switches and push-keys, and latches key-press events until software reads them. It produces the 13-bit `io_in` vector consumed by the data-memory I/O decode, the input-direction counterpart of the `io_out` display path. It also accepts a one-cycle read strobe from the data-memory side, which clears pending key events.

## Interface
Parameters:
- `SW_W`, 10, number of slide switches
- `KEY_W`, 3, number of push-keys (raw keys active-low)
- `DEBOUNCE_CYCLES`, 50000, stable-sample count before an input change is accepted (1 ms at 50 MHz); legal range 2..2^20

Ports:
- `clock`  in  1  system clock, same as the CPU clock
- `reset`  in  1  asynchronous, active-high reset
- `sw_raw`  in  SW_W  raw switch levels, asynchronous
- `key_raw`  in  KEY_W  raw keys, asynchronous, 0 = pressed
- `key_rd`  in  1  one-cycle strobe from the data-memory side when the CPU reads the key address
- `io_in`  out  SW_W+KEY_W  {key_event[KEY_W-1:0], sw_stable[SW_W-1:0]}
- `irq`  out  1  any key event pending (present only with SC_IO_IRQ_EN)

## Operation
- Every raw bit passes through a 2-flop synchronizer, then its own debounce counter.
- Debounce per bit:
  - if the synced value equals the stable value, the counter clears to 0;
  - otherwise the counter increments;
  - when the counter equals DEBOUNCE_CYCLES-1 and the synced value still differs, the stable value takes the synced value and the counter clears.
- Any bounce back to the stable value before the terminal count discards the change, and the count restarts from 0.
- `sw_stable` drives `io_in[SW_W-1:0]` directly. Levels only, no events.
- A key press is a stable key transition from 1 to 0. It sets `key_event[i]`. Release sets nothing.
- `key_rd` high clears all `key_event` bits on the next edge.
- If `key_rd` and a press of key i occur in the same cycle, `key_event[i]` is 1 afterwards (set wins). Other bits still clear.
- Pending events are sticky. Repeated presses while a bit is pending leave it at 1, with no counting.
- The counter width is $clog2(DEBOUNCE_CYCLES). It never wraps, because it clears at the terminal count.

## Timing
- Reset values: synchronizer flops sw=0, key=1 (released); `sw_stable`=0; key stable=1; counters 0; `key_event`=0; `io_in`=0; `irq`=0.
- Because keys reset to the released state, no spurious event is produced out of reset, even if a key is held.
- Latency from a clean raw change to `io_in`: 2 synchronizer cycles + DEBOUNCE_CYCLES cycles, with `io_in` registered.
- `key_event` rises on the same edge that updates the key's stable value.
- `key_rd` takes effect on the following edge. A CPU load in the same cycle sees the pre-clear value.
- Reset mid-debounce abandons the count. After reset deassertion, a held switch needs the full latency again.

## Configuration
- `SC_IO_IRQ_EN` defined:
  - the `irq` port exists;
  - `irq` is a registered OR of the next-state `key_event` bits, so it rises on the same edge as the event bit and falls on the edge that clears the last pending bit.
- `SC_IO_IRQ_EN` undefined: no `irq` port, no logic. All other behaviour is identical.

## Structure
- Package `sc_io_pkg`:
  - default SW_W/KEY_W/DEBOUNCE_CYCLES constants;
  - `io_in` field offsets (SW_LSB=0, KEY_LSB=SW_W);
  - key released level constant (1).
- Sub-module `sc_debounce`:
  - one bit: synchronizer + counter + stable register;
  - parameterized by DEBOUNCE_CYCLES and reset level;
  - instantiated SW_W+KEY_W times via generate.
- Top level holds only the event latch, `irq` logic and output packing.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8.
1. Reset with `key_raw`=3'b000 held, release reset. Required: `io_in`=0 for 20 cycles; `key_event` stays 0 until a key rises then falls again.
2. Drive `sw_raw`=10'h2A5 cleanly. Required: `io_in[9:0]`=10'h2A5 exactly 10 cycles later, not at cycle 9.
3. Toggle `sw_raw[0]` 0→1→0 with 5-cycle pulses for 40 cycles, then hold 1. Required: `io_in[0]` stays 0 during toggling and becomes 1 ten cycles after the final hold.
4. Press key 1 (`key_raw`=3'b101) and hold, then pulse `key_rd`. Required: `io_in[11]`=1 after 10 cycles; 0 one cycle after `key_rd`; no re-set while the key stays held.
5. Assert `key_rd` in the exact cycle key 2's stable value falls while `key_event[0]`=1. Required: afterwards `key_event`=3'b100.
6. Run with SC_IO_IRQ_EN defined. Required: `irq` rises with the first event, stays 1 across a second event, and falls one edge after `key_rd`.
